// File: rtl/fa_serial_adder.sv
// Bit-serial adder: one full-adder cell processes an LSB-first operand pair over BIT cycles.
// The result is published on sum/cout only when the final bit is done, so sum/cout never show partial values.
module fa_serial_adder #(
    parameter int BIT = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [BIT-1:0] a,
    input  logic [BIT-1:0] b,
    input  logic           cin,
    output logic           busy,
    output logic           done,
    output logic [BIT-1:0] sum,
    output logic           cout
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int            CW   = $clog2(BIT);
    localparam logic [CW-1:0] LAST = CW'(BIT - 1);

    state_t         state;
    state_t         state_next;
    logic [BIT-1:0] a_sr;
    logic [BIT-1:0] b_sr;
    logic [BIT-1:0] sum_sr;
    logic           carry;
    logic [CW-1:0]  cnt;

    logic fa_s;
    logic fa_c;
    logic last_bit;

    assign fa_s     = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_c     = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign last_bit = (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= {fa_s, sum_sr[BIT-1:1]};
                    carry  <= fa_c;
                    cnt    <= cnt + CW'(1);
                    // The last bit is folded in directly, since sum_sr itself lags one edge behind.
                    if (last_bit) begin
                        sum  <= {fa_s, sum_sr[BIT-1:1]};
                        cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
